// File: rtl/serial_tx_framer.sv
// Parametrised serial transmitter: frames words LSB-first as start, data, optional parity, stop,
// with a valid/ready input, a one-word holding buffer and a programmable bit period.
`timescale 1ns/1ps
module serial_tx_framer #(
    parameter int unsigned DATA_WIDTH   = 7,
    parameter int unsigned PARITY_MODE  = 1,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CntW  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  DataLast = CntW'(DATA_WIDTH - 1);
    localparam logic [CntW-1:0]  StopLast = CntW'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                  state_q, state_d;
    logic [BaudW-1:0]        baud_q, baud_d;
    logic [CntW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0]   buf_data_q, buf_data_d;
    logic                    buf_par_q, buf_par_d;
    logic                    so_q, so_d;
    logic                    busy_q, busy_d;
    logic                    fd_q, fd_d;
    logic                    bit_end;
    logic                    load;

    assign tx_ready   = ~buf_full_q;
    assign serial_out = so_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        buf_par_d  = buf_par_q;
        load       = 1'b0;
        bit_end    = (baud_q == BaudLast);

        if (state_q != StIdle) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                load   = buf_full_q;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DataLast) begin
                        state_d = (PARITY_MODE != 0) ? StParity : StStop;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    bit_d   = '0;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (bit_q == StopLast) begin
                        // A buffered word chains straight into the next start bit.
                        if (buf_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            state_d    = StStart;
            bit_d      = '0;
            baud_d     = '0;
            shift_d    = buf_data_q;
            par_d      = buf_par_q;
            buf_full_d = 1'b0;
        end

        // Load and accept are exclusive: load needs a full buffer, accept an empty one.
        if (tx_valid && !buf_full_q) begin
            buf_full_d = 1'b1;
            buf_data_d = tx_data;
            buf_par_d  = (PARITY_MODE == 2) ? ~^tx_data : ^tx_data;
        end
    end

    // Outputs are derived from next state so the registered line lines up with the state.
    always_comb begin
        unique case (state_d)
            StIdle:   so_d = 1'b1;
            StStart:  so_d = 1'b0;
            StData:   so_d = shift_d[0];
            StParity: so_d = par_d;
            StStop:   so_d = 1'b1;
            default:  so_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
        fd_d   = (state_d == StStop) && (baud_d == BaudLast) && (bit_d == StopLast);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            buf_par_q  <= 1'b0;
            so_q       <= 1'b1;
            busy_q     <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            buf_par_q  <= buf_par_d;
            so_q       <= so_d;
            busy_q     <= busy_d;
            fd_q       <= fd_d;
        end
    end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Bench for serial_tx_framer: three configurations driven with random words and compared,
// cycle by cycle, against a frame-schedule model built from the framing rules.
`timescale 1ns/1ps
module tb_serial_tx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] vld;
    logic [6:0] dat0;
    logic [7:0] dat1;
    logic [4:0] dat2;
    logic [2:0] so, rdy, bsy, fd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_tx_framer #(.DATA_WIDTH(7), .PARITY_MODE(1), .CLKS_PER_BIT(1), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_data(dat0), .tx_ready(rdy[0]),
        .serial_out(so[0]), .busy(bsy[0]), .frame_done(fd[0])
    );
    serial_tx_framer #(.DATA_WIDTH(8), .PARITY_MODE(2), .CLKS_PER_BIT(4), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_data(dat1), .tx_ready(rdy[1]),
        .serial_out(so[1]), .busy(bsy[1]), .frame_done(fd[1])
    );
    serial_tx_framer #(.DATA_WIDTH(5), .PARITY_MODE(0), .CLKS_PER_BIT(1), .STOP_BITS(1)) u_c (
        .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_data(dat2), .tx_ready(rdy[2]),
        .serial_out(so[2]), .busy(bsy[2]), .frame_done(fd[2])
    );

    function automatic void cfg(input int inst, output int w, output int pm, output int cpb,
                                output int sb);
        case (inst)
            0:       begin w = 7; pm = 1; cpb = 1; sb = 1; end
            1:       begin w = 8; pm = 2; cpb = 4; sb = 2; end
            default: begin w = 5; pm = 0; cpb = 1; sb = 1; end
        endcase
    endfunction

    task automatic drive(input int inst, input logic v, input logic [15:0] d);
        vld[inst] = v;
        case (inst)
            0:       dat0 = d[6:0];
            1:       dat1 = d[7:0];
            default: dat2 = d[4:0];
        endcase
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int inst, input logic e_so, input logic e_rdy,
                           input logic e_bsy, input logic e_fd);
        chk({tag, " serial_out"}, so[inst], e_so);
        chk({tag, " tx_ready"}, rdy[inst], e_rdy);
        chk({tag, " busy"}, bsy[inst], e_bsy);
        chk({tag, " frame_done"}, fd[inst], e_fd);
    endtask

    // Producer offers n words with tx_valid held throughout, junk data while not ready.
    // Schedule: word k is loaded at edge 1+k*F and its frame fills cycles 1+k*F..(k+1)*F.
    // abort_at >= 0 pulses reset asynchronously in that cycle and ends the stream.
    task automatic run_stream(input int inst, input int n, input int first, input int abort_at);
        int w, pm, cpb, sb, f, ones, nxt;
        logic [15:0] words[$];
        logic [15:0] mask, d;
        logic wave[$];
        logic e_so, e_rdy, e_bsy, e_fd, par;
        string tag;
        cfg(inst, w, pm, cpb, sb);
        f    = (1 + w + ((pm != 0) ? 1 : 0) + sb) * cpb;
        mask = 16'((1 << w) - 1);
        for (int k = 0; k < n; k++) begin
            d = (k == 0 && first >= 0) ? 16'(first) : (16'($urandom) & mask);
            words.push_back(d);
            ones = 0;
            for (int i = 0; i < w; i++) ones += int'(d[i]);
            par = (pm == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            for (int r = 0; r < cpb; r++) wave.push_back(1'b0);
            for (int i = 0; i < w; i++)
                for (int r = 0; r < cpb; r++) wave.push_back(d[i]);
            if (pm != 0)
                for (int r = 0; r < cpb; r++) wave.push_back(par);
            for (int r = 0; r < sb * cpb; r++) wave.push_back(1'b1);
        end
        drive(inst, 1'b1, words[0]);
        nxt = 1;
        for (int c = 0; c <= n * f + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            e_bsy = (c >= 1) && (c <= n * f);
            e_so  = e_bsy ? wave[c - 1] : 1'b1;
            e_fd  = e_bsy && (((c - 1) % f) == f - 1);
            e_rdy = (c > 1 + (n - 1) * f) || ((c >= 1) && (((c - 1) % f) == 0));
            tag   = $sformatf("inst%0d cyc%0d", inst, c);
            chk_all(tag, inst, e_so, e_rdy, e_bsy, e_fd);
            if (c == abort_at) begin
                #2 rst = 1'b1;
                #1 chk_all({tag, " async_rst"}, inst, 1'b1, 1'b1, 1'b0, 1'b0);
                #1 rst = 1'b0;
                drive(inst, 1'b0, 16'h0);
                return;
            end
            if (nxt < n) begin
                if (e_rdy) begin
                    drive(inst, 1'b1, words[nxt]);
                    nxt++;
                end else begin
                    drive(inst, 1'b1, 16'($urandom));
                end
            end else begin
                drive(inst, 1'b0, 16'($urandom));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk_all($sformatf("reset inst%0d", i), i, 1'b1, 1'b1, 1'b0,
                                            1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_stream(0, 1, 'h55, -1);
        run_stream(1, 1, 'hA3, -1);
        run_stream(0, 3, -1, -1);
        run_stream(2, 1, 'h1F, -1);
        run_stream(2, 3, -1, -1);
        run_stream(1, 2, -1, -1);

        // Reset in the DATA state with a second word buffered: both must be dropped.
        run_stream(0, 2, -1, 5);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk_all($sformatf("post_rst cyc%0d", c), 0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        run_stream(0, 1, -1, -1);
        run_stream(0, 2, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
